// File: rtl/memshare_vn_iblut_loader.sv
// Remap-side write controller for the shared IB-RAM column banks: streams
// VN_LOAD_CYCLE entries into one VN IB-LUT and muxes the common map/remap address.
module memshare_vn_iblut_loader #(
  parameter int ADDR_WIDTH    = 6,
  parameter int VN_LOAD_CYCLE = 64,
  parameter int MSG_WIDTH     = 4,
  parameter int BANK_NUM      = 2,
  localparam int BANK_W       = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
  localparam int CNT_W        = $clog2(VN_LOAD_CYCLE)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load_req_i,
  input  logic [BANK_W-1:0]     load_bank_i,
  input  logic                  abort_i,
  input  logic                  src_valid_i,
  input  logic [MSG_WIDTH-1:0]  src_data_i,
  output logic                  src_ready_o,
  input  logic [ADDR_WIDTH-1:0] map_addr_i,
  output logic [MSG_WIDTH-1:0]  remap_data_o,
  output logic [ADDR_WIDTH-1:0] map_remap_addr_o,
  output logic [BANK_NUM-1:0]   remap_en_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST      = CNT_W'(VN_LOAD_CYCLE - 1);
  localparam logic [BANK_W:0]  BANK_LIM  = (BANK_W + 1)'(BANK_NUM);

  logic [1:0]            state;
  logic [CNT_W-1:0]      count;
  logic [BANK_W-1:0]     bank_q;
  logic [BANK_NUM-1:0]   wr_en_n;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [MSG_WIDTH-1:0]  wr_data;
  logic                  err_q;
  logic                  accept;
  logic                  bank_bad;

  // Handshake: an entry transfers on any cycle where src_valid_i and src_ready_o
  // are both high; ready depends only on state and abort_i, never on valid, and
  // the source must hold data stable while valid is high without ready.
  assign src_ready_o = (state == S_LOAD) && !abort_i;
  assign accept      = src_valid_i && src_ready_o;
  assign bank_bad    = {1'b0, load_bank_i} >= BANK_LIM;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      bank_q  <= '0;
      wr_en_n <= '1;
      wr_addr <= '0;
      wr_data <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_en_n <= '1;
      err_q   <= load_req_i && ((state != S_IDLE) || bank_bad);
      // A write is issued exactly one cycle after its accept, whatever the FSM does next.
      if (accept) begin
        wr_en_n[bank_q] <= 1'b0;
        wr_addr         <= ADDR_WIDTH'(count);
        wr_data         <= src_data_i;
        count           <= count + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (load_req_i && !bank_bad) begin
            state  <= S_LOAD;
            bank_q <= load_bank_i;
            count  <= '0;
          end
        end
        S_LOAD: begin
          if (abort_i) begin
            state <= S_IDLE;
            count <= '0;
          end else if (accept && (count == LAST)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoder map address passes through whenever no bank is being written.
  assign map_remap_addr_o = (&wr_en_n) ? map_addr_i : wr_addr;
  assign remap_en_n_o     = wr_en_n;
  assign remap_data_o     = wr_data;
  assign busy_o           = (state != S_IDLE);
  assign done_o           = (state == S_DONE);
  assign err_o            = err_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_memshare_vn_iblut_loader.sv
// Bench for memshare_vn_iblut_loader: random stimulus against a transaction-level
// model of the remap (entry index, target bank, expected write queue).
module tb_memshare_vn_iblut_loader;
  localparam int AW = 6;
  localparam int N  = 64;
  localparam int MW = 4;
  localparam int BN = 2;

  logic          sys_clk = 1'b0;
  logic          rst, load_req_i, abort_i, src_valid_i;
  logic [0:0]    load_bank_i;
  logic [MW-1:0] src_data_i;
  logic [AW-1:0] map_addr_i;
  logic          src_ready_o, busy_o, done_o, err_o;
  logic [MW-1:0] remap_data_o;
  logic [AW-1:0] map_remap_addr_o;
  logic [BN-1:0] remap_en_n_o;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = no remap, 1 = taking entries, 2 = remap just completed.
  int            m_phase, m_idx, m_bank;
  logic          e_ready, e_busy, e_done, e_err, obs_ready;
  logic [BN-1:0] e_en_n;
  logic [AW-1:0] e_addr;
  logic [10:0]   exp_q[$];
  logic [10:0]   got_w, exp_w;

  memshare_vn_iblut_loader #(
    .ADDR_WIDTH(AW), .VN_LOAD_CYCLE(N), .MSG_WIDTH(MW), .BANK_NUM(BN)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .load_req_i(load_req_i), .load_bank_i(load_bank_i),
    .abort_i(abort_i), .src_valid_i(src_valid_i), .src_data_i(src_data_i),
    .src_ready_o(src_ready_o), .map_addr_i(map_addr_i), .remap_data_o(remap_data_o),
    .map_remap_addr_o(map_remap_addr_o), .remap_en_n_o(remap_en_n_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .state_dbg(state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  // Drives one clock cycle of inputs and advances the model; starts and ends 1ns after a posedge.
  task automatic cycle(input logic r, input logic req, input logic bank, input logic ab,
                       input logic v, input logic [MW-1:0] d, input logic [AW-1:0] ma);
    logic          wr;
    logic [AW-1:0] wa;
    rst = r; load_req_i = req; load_bank_i = bank; abort_i = ab;
    src_valid_i = v; src_data_i = d; map_addr_i = ma;
    #4;
    obs_ready = src_ready_o;
    e_ready   = (m_phase == 1) && !ab;
    wr = 1'b0;
    wa = '0;
    if (r) begin
      m_phase = 0; m_idx = 0; e_err = 1'b0;
    end else begin
      e_err = req && (m_phase != 0 || int'(bank) >= BN);
      case (m_phase)
        0: if (req && int'(bank) < BN) begin m_phase = 1; m_idx = 0; m_bank = int'(bank); end
        1: begin
          if (ab) begin
            m_phase = 0; m_idx = 0;
          end else if (v) begin
            wr = 1'b1;
            wa = AW'(m_idx);
            exp_q.push_back({m_bank[0], wa, d});
            m_idx++;
            if (m_idx == N) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
    e_en_n = '1;
    if (wr) e_en_n[m_bank] = 1'b0;
    e_addr = wr ? wa : ma;
    e_busy = (m_phase != 0);
    e_done = (m_phase == 2);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 6'd5);
      checks++; if (remap_en_n_o !== 2'b11) begin errors++; $display("FAIL reset_en_n got %b exp 11", remap_en_n_o); end
      checks++; if (remap_data_o !== 4'h0) begin errors++; $display("FAIL reset_data got %h exp 0", remap_data_o); end
      checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy_o, done_o, err_o}); end
      checks++; if (map_remap_addr_o !== 6'd5) begin errors++; $display("FAIL reset_addr got %0d exp 5", map_remap_addr_o); end
    end
    checks++; if (src_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", src_ready_o); end
  endtask

  task automatic test_full_load_bank0();
    for (int c = 0; c < 70; c++) begin
      cycle(1'b0, c == 0, 1'b0, 1'b0, 1'b1, MW'(c - 1), AW'($urandom));
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL full_ready c=%0d got %b exp %b", c, obs_ready, e_ready); end
      checks++; if (remap_en_n_o !== e_en_n) begin errors++; $display("FAIL full_en_n c=%0d got %b exp %b", c, remap_en_n_o, e_en_n); end
      checks++; if (map_remap_addr_o !== e_addr) begin errors++; $display("FAIL full_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, e_addr); end
      checks++; if ({busy_o, done_o, err_o} !== {e_busy, e_done, e_err}) begin errors++; $display("FAIL full_status c=%0d got %b exp %b", c, {busy_o, done_o, err_o}, {e_busy, e_done, e_err}); end
      if (remap_en_n_o !== 2'b11) begin
        checks++;
        got_w = {remap_en_n_o[0], map_remap_addr_o, remap_data_o};
        if (exp_q.size() == 0) begin errors++; $display("FAIL full_write c=%0d got %h exp none", c, got_w); end
        else begin exp_w = exp_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL full_write c=%0d got %h exp %h", c, got_w, exp_w); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_missing got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_gapped_bank1();
    for (int c = 0; c < 140; c++) begin
      cycle(1'b0, c == 0, 1'b1, 1'b0, c % 2 == 1, MW'($urandom), AW'($urandom));
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL gap_ready c=%0d got %b exp %b", c, obs_ready, e_ready); end
      checks++; if (remap_en_n_o !== e_en_n) begin errors++; $display("FAIL gap_en_n c=%0d got %b exp %b", c, remap_en_n_o, e_en_n); end
      checks++; if (map_remap_addr_o !== e_addr) begin errors++; $display("FAIL gap_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, e_addr); end
      checks++; if ({busy_o, done_o, err_o} !== {e_busy, e_done, e_err}) begin errors++; $display("FAIL gap_status c=%0d got %b exp %b", c, {busy_o, done_o, err_o}, {e_busy, e_done, e_err}); end
      if (remap_en_n_o !== 2'b11) begin
        checks++;
        got_w = {remap_en_n_o[0], map_remap_addr_o, remap_data_o};
        if (exp_q.size() == 0) begin errors++; $display("FAIL gap_write c=%0d got %h exp none", c, got_w); end
        else begin exp_w = exp_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL gap_write c=%0d got %h exp %h", c, got_w, exp_w); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gap_missing got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_idle_sweep();
    for (int c = 0; c < 64; c++) begin
      cycle(1'b0, 1'b0, 1'b0, c % 3 == 0, 1'b1, MW'($urandom), AW'(c));
      checks++; if (remap_en_n_o !== 2'b11) begin errors++; $display("FAIL sweep_en_n c=%0d got %b exp 11", c, remap_en_n_o); end
      checks++; if (map_remap_addr_o !== AW'(c)) begin errors++; $display("FAIL sweep_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, c); end
      checks++; if ({obs_ready, busy_o, done_o, err_o} !== 4'b0000) begin errors++; $display("FAIL sweep_status c=%0d got %b exp 0000", c, {obs_ready, busy_o, done_o, err_o}); end
    end
  endtask

  // Entries 0..10 accepted, abort on the next cycle, then a fresh full load.
  task automatic test_abort();
    logic bank;
    bank = 1'($urandom);
    for (int c = 0; c < 90; c++) begin
      cycle(1'b0, (c == 0) || (c == 16), bank, c == 12, (c != 0) && (c != 16), MW'($urandom), AW'($urandom));
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL abort_ready c=%0d got %b exp %b", c, obs_ready, e_ready); end
      checks++; if (remap_en_n_o !== e_en_n) begin errors++; $display("FAIL abort_en_n c=%0d got %b exp %b", c, remap_en_n_o, e_en_n); end
      checks++; if (map_remap_addr_o !== e_addr) begin errors++; $display("FAIL abort_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, e_addr); end
      checks++; if ({busy_o, done_o, err_o} !== {e_busy, e_done, e_err}) begin errors++; $display("FAIL abort_status c=%0d got %b exp %b", c, {busy_o, done_o, err_o}, {e_busy, e_done, e_err}); end
      if (remap_en_n_o !== 2'b11) begin
        checks++;
        got_w = {remap_en_n_o[0], map_remap_addr_o, remap_data_o};
        if (exp_q.size() == 0) begin errors++; $display("FAIL abort_write c=%0d got %h exp none", c, got_w); end
        else begin exp_w = exp_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL abort_write c=%0d got %h exp %h", c, got_w, exp_w); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // load_req_i pulsed in the cycle entry 20 is accepted.
  task automatic test_load_req_err();
    for (int c = 0; c < 72; c++) begin
      cycle(1'b0, (c == 0) || (c == 21), 1'($urandom), 1'b0, 1'b1, MW'($urandom), AW'($urandom));
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL req_ready c=%0d got %b exp %b", c, obs_ready, e_ready); end
      checks++; if (remap_en_n_o !== e_en_n) begin errors++; $display("FAIL req_en_n c=%0d got %b exp %b", c, remap_en_n_o, e_en_n); end
      checks++; if (map_remap_addr_o !== e_addr) begin errors++; $display("FAIL req_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, e_addr); end
      checks++; if ({busy_o, done_o, err_o} !== {e_busy, e_done, e_err}) begin errors++; $display("FAIL req_status c=%0d got %b exp %b", c, {busy_o, done_o, err_o}, {e_busy, e_done, e_err}); end
      if (remap_en_n_o !== 2'b11) begin
        checks++;
        got_w = {remap_en_n_o[0], map_remap_addr_o, remap_data_o};
        if (exp_q.size() == 0) begin errors++; $display("FAIL req_write c=%0d got %h exp none", c, got_w); end
        else begin exp_w = exp_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL req_write c=%0d got %h exp %h", c, got_w, exp_w); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL req_missing got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // Reset asserted in the cycle entry 30 would be accepted.
  task automatic test_reset_mid_load();
    for (int c = 0; c < 36; c++) begin
      cycle(c == 31, c == 0, 1'($urandom), 1'b0, 1'b1, MW'($urandom), AW'($urandom));
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL rstmid_ready c=%0d got %b exp %b", c, obs_ready, e_ready); end
      checks++; if (remap_en_n_o !== e_en_n) begin errors++; $display("FAIL rstmid_en_n c=%0d got %b exp %b", c, remap_en_n_o, e_en_n); end
      checks++; if (map_remap_addr_o !== e_addr) begin errors++; $display("FAIL rstmid_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, e_addr); end
      checks++; if ({busy_o, done_o, err_o} !== {e_busy, e_done, e_err}) begin errors++; $display("FAIL rstmid_status c=%0d got %b exp %b", c, {busy_o, done_o, err_o}, {e_busy, e_done, e_err}); end
      if (c == 31) begin
        checks++; if (remap_data_o !== 4'h0) begin errors++; $display("FAIL rstmid_data got %h exp 0", remap_data_o); end
      end
      if (remap_en_n_o !== 2'b11) begin
        checks++;
        got_w = {remap_en_n_o[0], map_remap_addr_o, remap_data_o};
        if (exp_q.size() == 0) begin errors++; $display("FAIL rstmid_write c=%0d got %h exp none", c, got_w); end
        else begin exp_w = exp_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL rstmid_write c=%0d got %h exp %h", c, got_w, exp_w); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 999) == 0, $urandom_range(0, 39) == 0, 1'($urandom),
            $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, MW'($urandom), AW'($urandom));
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, obs_ready, e_ready); end
      checks++; if (remap_en_n_o !== e_en_n) begin errors++; $display("FAIL rand_en_n c=%0d got %b exp %b", c, remap_en_n_o, e_en_n); end
      checks++; if (map_remap_addr_o !== e_addr) begin errors++; $display("FAIL rand_addr c=%0d got %0d exp %0d", c, map_remap_addr_o, e_addr); end
      checks++; if ({busy_o, done_o, err_o} !== {e_busy, e_done, e_err}) begin errors++; $display("FAIL rand_status c=%0d got %b exp %b", c, {busy_o, done_o, err_o}, {e_busy, e_done, e_err}); end
      if (remap_en_n_o !== 2'b11) begin
        checks++;
        got_w = {remap_en_n_o[0], map_remap_addr_o, remap_data_o};
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_write c=%0d got %h exp none", c, got_w); end
        else begin exp_w = exp_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL rand_write c=%0d got %h exp %h", c, got_w, exp_w); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing got %0d exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; load_req_i = 1'b0; load_bank_i = 1'b0; abort_i = 1'b0;
    src_valid_i = 1'b0; src_data_i = '0; map_addr_i = '0;
    m_phase = 0; m_idx = 0; m_bank = 0;
    @(posedge sys_clk);
    #1;
    test_reset();
    test_full_load_bank0();
    test_gapped_bank1();
    test_idle_sweep();
    test_abort();
    test_load_req_err();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
